axis_alu_pipe: RTL and testbench

Pipelined, multi-lane AXI-Stream fixed-point ALU with a per-beat runtime opcode, optional saturation, and a packet-scoped multiply-accumulate mode. CHANNELS lanes share one handshake. Operands pass through a PIPE_DEPTH-stage stallable pipeline into a 2-entry output skid buffer, so `s_axis_tready` never depends combinationally on `m_axis_tready`. It is the runtime-configurable successor to the fixed-op ALU wrappers in the KAN datapath, and feeds the spline/weight accumulation stages.

---
 rtl/axis_alu_pipe.sv | 226 ++++++++++++++++++++++
 tb/tb_axis_alu_pipe.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_alu_pipe.sv
// axis_alu_pipe: multi-lane AXI-Stream fixed-point ALU. Operands are
// pre-computed at full precision on entry, delayed through PIPE_DEPTH
// stallable stages, narrowed (and accumulated for MAC) at the last stage,
// then held in a two-entry skid buffer so s_axis_tready is registered-only.
//
// Handshake: a beat transfers on a rising edge where tvalid && tready are
// both high; tvalid never waits on tready, and once m_axis_tvalid is high the
// payload (tdata/tsat/tlast/tuser) holds until m_axis_tready accepts it.
module axis_alu_pipe #(
  parameter int OP0_WIDTH   = 16,
  parameter int OP1_WIDTH   = 16,
  parameter int RSLT_WIDTH  = 16,
  parameter int FRAC_SHIFT  = 0,
  parameter int CHANNELS    = 1,
  parameter int PIPE_DEPTH  = 2,
  parameter int SATURATE    = 1,
  parameter int LAST_ENABLE = 1,
  parameter int USER_ENABLE = 1,
  parameter int USER_WIDTH  = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CHANNELS*OP0_WIDTH-1:0]  s_axis_tdata_op0,
  input  logic [CHANNELS*OP1_WIDTH-1:0]  s_axis_tdata_op1,
  input  logic [2:0]                     s_axis_op,
  input  logic                           s_axis_tlast,
  input  logic [USER_WIDTH-1:0]          s_axis_tuser,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  output logic [CHANNELS*RSLT_WIDTH-1:0] m_axis_tdata,
  output logic [CHANNELS-1:0]            m_axis_tsat,
  output logic                           m_axis_tlast,
  output logic [USER_WIDTH-1:0]          m_axis_tuser,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready
);

  localparam int PW     = OP0_WIDTH + OP1_WIDTH;
  localparam int OMAX   = (OP0_WIDTH > OP1_WIDTH) ? OP0_WIDTH : OP1_WIDTH;
  localparam int AW     = OMAX + 1;
  localparam int M1     = (PW > AW) ? PW : AW;
  // Two guard bits cover the rounding add and the MAC accumulator sum.
  localparam int IW     = ((M1 > RSLT_WIDTH) ? M1 : RSLT_WIDTH) + 2;
  localparam int LST    = PIPE_DEPTH - 1;
  localparam int RND_SH = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;

  typedef logic signed [IW-1:0] wide_t;

  localparam wide_t RND  = (FRAC_SHIFT > 0) ? ({{(IW-1){1'b0}}, 1'b1} << RND_SH) : {IW{1'b0}};
  localparam wide_t RMAX = {{(IW-RSLT_WIDTH+1){1'b0}}, {(RSLT_WIDTH-1){1'b1}}};
  localparam wide_t RMIN = {{(IW-RSLT_WIDTH+1){1'b1}}, {(RSLT_WIDTH-1){1'b0}}};

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MLT = 3'd2;
  localparam logic [2:0] OP_ABS = 3'd3;
  localparam logic [2:0] OP_MIN = 3'd4;
  localparam logic [2:0] OP_MAX = 3'd5;
  localparam logic [2:0] OP_MAC = 3'd6;

  if (PIPE_DEPTH < 1 || PIPE_DEPTH > 4) begin : g_bad_depth
    $error("axis_alu_pipe: PIPE_DEPTH must be in 1..4");
  end

  // Narrow a full-precision value to RSLT_WIDTH; returns {flag, result}.
  function automatic logic [RSLT_WIDTH:0] narrow(input wide_t v);
    logic [RSLT_WIDTH-1:0] t;
    logic                  s;
    t = v[RSLT_WIDTH-1:0];
    s = 1'b0;
    if (SATURATE != 0) begin
      if (v > RMAX) begin
        t = RMAX[RSLT_WIDTH-1:0];
        s = 1'b1;
      end else if (v < RMIN) begin
        t = RMIN[RSLT_WIDTH-1:0];
        s = 1'b1;
      end
    end else begin
      s = (IW'(signed'(t)) != v);
    end
    return {s, t};
  endfunction

  // Pipeline stage state
  logic [PIPE_DEPTH-1:0] v_q;
  logic [PIPE_DEPTH-1:0] last_q;
  logic [2:0]            op_q   [PIPE_DEPTH];
  logic [USER_WIDTH-1:0] user_q [PIPE_DEPTH];
  wide_t                 pre_q  [PIPE_DEPTH][CHANNELS];

  // Skid buffer and accumulators
  logic                           out_valid_q, tmp_valid_q;
  logic [CHANNELS*RSLT_WIDTH-1:0] out_data_q, tmp_data_q;
  logic [CHANNELS-1:0]            out_sat_q, tmp_sat_q;
  logic                           out_last_q, tmp_last_q;
  logic [USER_WIDTH-1:0]          out_user_q, tmp_user_q;
  logic signed [RSLT_WIDTH-1:0]   acc_q [CHANNELS];

  wide_t                          pre_d [CHANNELS];
  logic [CHANNELS*RSLT_WIDTH-1:0] res_d;
  logic [CHANNELS-1:0]            sat_d;
  logic                           ce, take;

  // Stages advance together whenever the last stage can leave or is empty.
  assign ce            = !v_q[LST] || !tmp_valid_q;
  assign take          = v_q[LST] && !tmp_valid_q;
  assign s_axis_tready = ce && rst_n;

  // Full-precision per-lane operation on the incoming beat.
  always_comb begin
    wide_t a_w, b_w, prod_w, prod_r;
    for (int i = 0; i < CHANNELS; i++) begin
      a_w    = IW'(signed'(s_axis_tdata_op0[i*OP0_WIDTH +: OP0_WIDTH]));
      b_w    = IW'(signed'(s_axis_tdata_op1[i*OP1_WIDTH +: OP1_WIDTH]));
      prod_w = a_w * b_w;
      prod_r = (prod_w + RND) >>> FRAC_SHIFT;
      pre_d[i] = '0;
      case (s_axis_op)
        OP_ADD:         pre_d[i] = a_w + b_w;
        OP_SUB:         pre_d[i] = a_w - b_w;
        OP_MLT, OP_MAC: pre_d[i] = prod_r;
        OP_ABS:         pre_d[i] = a_w[IW-1] ? -a_w : a_w;
        OP_MIN:         pre_d[i] = (a_w < b_w) ? a_w : b_w;
        OP_MAX:         pre_d[i] = (a_w > b_w) ? a_w : b_w;
        default:        pre_d[i] = '0;
      endcase
    end
  end

  // Last-stage narrowing; MAC adds the lane accumulator before narrowing.
  always_comb begin
    wide_t               sum;
    logic [RSLT_WIDTH:0] nr;
    res_d = '0;
    sat_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sum = (op_q[LST] == OP_MAC) ? IW'(acc_q[i]) + pre_q[LST][i] : pre_q[LST][i];
      nr  = narrow(sum);
      res_d[i*RSLT_WIDTH +: RSLT_WIDTH] = nr[RSLT_WIDTH-1:0];
      sat_d[i] = nr[RSLT_WIDTH];
    end
  end

  // Stallable delay line carrying pre-results and sideband together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      last_q <= '0;
      for (int s = 0; s < PIPE_DEPTH; s++) begin
        op_q[s]   <= '0;
        user_q[s] <= '0;
        for (int i = 0; i < CHANNELS; i++) pre_q[s][i] <= '0;
      end
    end else if (ce) begin
      v_q[0]    <= s_axis_tvalid;
      last_q[0] <= s_axis_tlast;
      op_q[0]   <= s_axis_op;
      user_q[0] <= s_axis_tuser;
      for (int i = 0; i < CHANNELS; i++) pre_q[0][i] <= pre_d[i];
      for (int s = 1; s < PIPE_DEPTH; s++) begin
        v_q[s]    <= v_q[s-1];
        last_q[s] <= last_q[s-1];
        op_q[s]   <= op_q[s-1];
        user_q[s] <= user_q[s-1];
        for (int i = 0; i < CHANNELS; i++) pre_q[s][i] <= pre_q[s-1][i];
      end
    end
  end

  // Accumulators move only when a MAC beat leaves the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) acc_q[i] <= '0;
    end else if (take && op_q[LST] == OP_MAC) begin
      for (int i = 0; i < CHANNELS; i++)
        acc_q[i] <= last_q[LST] ? '0 : signed'(res_d[i*RSLT_WIDTH +: RSLT_WIDTH]);
    end
  end

  // Output register plus temp entry; temp only fills when the output stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
      out_last_q  <= 1'b0;
      out_user_q  <= '0;
      tmp_valid_q <= 1'b0;
      tmp_data_q  <= '0;
      tmp_sat_q   <= '0;
      tmp_last_q  <= 1'b0;
      tmp_user_q  <= '0;
    end else if (!out_valid_q || m_axis_tready) begin
      if (tmp_valid_q) begin
        out_valid_q <= 1'b1;
        out_data_q  <= tmp_data_q;
        out_sat_q   <= tmp_sat_q;
        out_last_q  <= tmp_last_q;
        out_user_q  <= tmp_user_q;
        tmp_valid_q <= 1'b0;
      end else if (take) begin
        out_valid_q <= 1'b1;
        out_data_q  <= res_d;
        out_sat_q   <= sat_d;
        out_last_q  <= last_q[LST];
        out_user_q  <= user_q[LST];
      end else begin
        out_valid_q <= 1'b0;
      end
    end else if (take) begin
      tmp_valid_q <= 1'b1;
      tmp_data_q  <= res_d;
      tmp_sat_q   <= sat_d;
      tmp_last_q  <= last_q[LST];
      tmp_user_q  <= user_q[LST];
    end
  end

  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tsat   = out_sat_q;
  assign m_axis_tlast  = (LAST_ENABLE != 0) ? out_last_q : 1'b1;
  assign m_axis_tuser  = (USER_ENABLE != 0) ? out_user_q : '0;

endmodule

// File: tb/tb_axis_alu_pipe.sv
// Bench for axis_alu_pipe: two instances (saturating integer, wrapping Q8)
// share one stimulus stream; a behavioural model predicts every beat.
module tb_axis_alu_pipe;

  localparam int CH    = 2;
  localparam int W     = 16;
  localparam int DEPTH = 2;
  localparam int EW    = 70;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [CH*W-1:0] s_op0, s_op1;
  logic [2:0]      s_op;
  logic            s_last, s_valid, m_ready;
  logic [0:0]      s_user;
  logic            s_ready_a, s_ready_b, m_valid_a, m_valid_b, m_last_a, m_last_b;
  logic [CH*W-1:0] m_data_a, m_data_b;
  logic [CH-1:0]   m_sat_a, m_sat_b;
  logic [0:0]      m_user_a, m_user_b;

  axis_alu_pipe #(.OP0_WIDTH(W), .OP1_WIDTH(W), .RSLT_WIDTH(W), .FRAC_SHIFT(0),
    .CHANNELS(CH), .PIPE_DEPTH(DEPTH), .SATURATE(1), .LAST_ENABLE(1),
    .USER_ENABLE(1), .USER_WIDTH(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .s_axis_tdata_op0(s_op0), .s_axis_tdata_op1(s_op1),
    .s_axis_op(s_op), .s_axis_tlast(s_last), .s_axis_tuser(s_user),
    .s_axis_tvalid(s_valid), .s_axis_tready(s_ready_a), .m_axis_tdata(m_data_a),
    .m_axis_tsat(m_sat_a), .m_axis_tlast(m_last_a), .m_axis_tuser(m_user_a),
    .m_axis_tvalid(m_valid_a), .m_axis_tready(m_ready));

  axis_alu_pipe #(.OP0_WIDTH(W), .OP1_WIDTH(W), .RSLT_WIDTH(W), .FRAC_SHIFT(8),
    .CHANNELS(CH), .PIPE_DEPTH(DEPTH), .SATURATE(0), .LAST_ENABLE(1),
    .USER_ENABLE(1), .USER_WIDTH(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_axis_tdata_op0(s_op0), .s_axis_tdata_op1(s_op1),
    .s_axis_op(s_op), .s_axis_tlast(s_last), .s_axis_tuser(s_user),
    .s_axis_tvalid(s_valid), .s_axis_tready(s_ready_b), .m_axis_tdata(m_data_b),
    .m_axis_tsat(m_sat_b), .m_axis_tlast(m_last_b), .m_axis_tuser(m_user_b),
    .m_axis_tvalid(m_valid_b), .m_axis_tready(m_ready));

  // ---------------- scoreboard state ----------------
  // Entry layout: {last, user, sat_b[1:0], data_b[31:0], sat_a[1:0], data_a[31:0]}
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs_q[$];
  longint        acc_a[CH], acc_b[CH];
  int            checks = 0;
  int            errors = 0;
  int            rnd_mode = 0;
  int            low_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference semantics of one lane at 64-bit precision.
  function automatic void ref_op(input int op, input longint a, input longint b,
                                 input longint acc, input int frac, input bit sat,
                                 output longint res, output bit ts);
    longint p, full;
    p = a * b;
    if (frac > 0) p = (p + (longint'(1) <<< (frac - 1))) >>> frac;
    case (op)
      0: full = a + b;
      1: full = a - b;
      2: full = p;
      3: full = (a < 0) ? -a : a;
      4: full = (a < b) ? a : b;
      5: full = (a > b) ? a : b;
      6: full = acc + p;
      default: full = 0;
    endcase
    if (sat) begin
      if (full > 32767)       begin res = 32767;  ts = 1'b1; end
      else if (full < -32768) begin res = -32768; ts = 1'b1; end
      else                    begin res = full;   ts = 1'b0; end
    end else begin
      res = longint'(shortint'(full));
      ts  = (res != full);
    end
  endfunction

  // ---------------- monitor / compare (negedge) ----------------
  logic [EW-1:0] obs_w;
  logic [31:0]   da, db;
  logic [1:0]    sa, sb;
  longint        ra, rb, la, lb;
  bit            ta, tb;

  always @(negedge clk) begin
    obs_w = {m_last_a, m_user_a, m_sat_b, m_data_b, m_sat_a, m_data_a};
    if (!rst_n) begin
      exp_q.delete();
      for (int l = 0; l < CH; l++) begin acc_a[l] = 0; acc_b[l] = 0; end
      chk("reset_outputs", 128'({s_ready_b, s_ready_a, m_valid_b, m_valid_a, m_last_b, m_user_b, obs_w}), 128'(0));
    end else begin
      chk("occupancy_max", 128'(exp_q.size() <= DEPTH + 2), 128'(1));
      if (!s_ready_a) chk("stall_only_when_full", 128'(exp_q.size() >= 3), 128'(1));
      if (m_valid_a || m_valid_b) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 128'(obs_w), 128'(0));
        end else begin
          chk("valid_both", 128'({m_valid_b, m_valid_a}), 128'(2'b11));
          chk("beat", 128'(obs_w), 128'(exp_q[0]));
          if (m_ready) begin
            void'(exp_q.pop_front());
            obs_q.push_back(obs_w);
          end
        end
      end
      if (s_valid && s_ready_a) begin
        for (int l = 0; l < CH; l++) begin
          la = longint'(shortint'(s_op0[l*W +: W]));
          lb = longint'(shortint'(s_op1[l*W +: W]));
          ref_op(int'(s_op), la, lb, acc_a[l], 0, 1'b1, ra, ta);
          ref_op(int'(s_op), la, lb, acc_b[l], 8, 1'b0, rb, tb);
          da[l*W +: W] = ra[15:0];
          db[l*W +: W] = rb[15:0];
          sa[l] = ta;
          sb[l] = tb;
          if (s_op == 3'd6) begin
            acc_a[l] = s_last ? 0 : ra;
            acc_b[l] = s_last ? 0 : rb;
          end
        end
        exp_q.push_back({s_last, s_user, sb, db, sa, da});
      end
    end
  end

  // ---------------- output ready driver ----------------
  always @(posedge clk) begin
    #1;
    if (low_cnt > 0) begin
      m_ready = 1'b0;
      low_cnt--;
    end else if (rnd_mode != 0) begin
      m_ready = 1'($urandom_range(0, 1));
    end else begin
      m_ready = 1'b1;
    end
  end

  // ---------------- driver tasks (called #1 after a posedge) ----------------
  task automatic send(input logic [2:0] op, input logic [15:0] a0, input logic [15:0] b0,
                      input logic [15:0] a1, input logic [15:0] b1, input logic last,
                      input logic user);
    bit ok;
    s_op0 = {a1, a0}; s_op1 = {b1, b0};
    s_op = op; s_last = last; s_user = user; s_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 100 && !ok; n++) begin
      @(negedge clk);
      if (s_ready_a) ok = 1'b1;
    end
    if (!ok) chk("accept_timeout", 128'(0), 128'(1));
    @(posedge clk); #1;
  endtask

  task automatic drain();
    bit ok;
    s_valid = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0) ok = 1'b1;
    end
    chk("drain_empty", 128'(exp_q.size()), 128'(0));
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'($urandom_range(0, 8));
      3: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // ---------------- main sequence ----------------
  longint pr;
  bit     pt;
  bit     got;

  initial begin
    s_op0 = '0; s_op1 = '0; s_op = '0; s_last = 1'b0; s_user = '0; s_valid = 1'b0;
    m_ready = 1'b1;

    // Pin the model against hand-computed values.
    ref_op(0, 32767, 1, 0, 0, 1'b1, pr, pt);  chk("model_add_sat", 128'({pt, pr[15:0]}), 128'({1'b1, 16'h7FFF}));
    ref_op(3, -32768, 0, 0, 0, 1'b1, pr, pt); chk("model_abs_sat", 128'({pt, pr[15:0]}), 128'({1'b1, 16'h7FFF}));
    ref_op(0, 32767, 1, 0, 0, 1'b0, pr, pt);  chk("model_add_wrap", 128'({pt, pr[15:0]}), 128'({1'b1, 16'h8000}));
    ref_op(2, 384, 256, 0, 8, 1'b0, pr, pt);  chk("model_q8_mlt", 128'({pt, pr[15:0]}), 128'({1'b0, 16'h0180}));
    ref_op(2, 1, 128, 0, 8, 1'b0, pr, pt);    chk("model_q8_round", 128'({pt, pr[15:0]}), 128'({1'b0, 16'h0001}));

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 128'(s_ready_a), 128'(1));
    @(posedge clk); #1;

    // Latency: ADD accepted at edge E0 is visible after E2.
    send(3'd0, 16'd3, 16'd4, 16'd10, 16'hFFFD, 1'b0, 1'b1);
    s_valid = 1'b0;
    @(negedge clk); chk("lat_after_e0", 128'(m_valid_a), 128'(0));
    @(negedge clk); chk("lat_after_e1", 128'(m_valid_a), 128'(0));
    @(negedge clk); chk("lat_after_e2", 128'(m_valid_a), 128'(1));
    chk("lat_data_a", 128'(m_data_a), 128'({16'd7, 16'd7}));
    chk("lat_data_b", 128'(m_data_b), 128'({16'd7, 16'd7}));
    @(posedge clk); #1;
    drain();

    // Saturation / wrap / fixed point.
    obs_q.delete();
    send(3'd0, 16'h7FFF, 16'h0001, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send(3'd3, 16'h8000, 16'h0000, 16'h8000, 16'h0000, 1'b0, 1'b0);
    send(3'd2, 16'h0180, 16'h0100, 16'h0180, 16'h0100, 1'b0, 1'b0);
    send(3'd2, 16'h0001, 16'h0080, 16'h0001, 16'h0080, 1'b0, 1'b0);
    drain();
    chk("sat_count", 128'(obs_q.size()), 128'(4));
    if (obs_q.size() == 4) begin
      chk("add_sat_a",  128'({obs_q[0][32], obs_q[0][15:0]}),  128'({1'b1, 16'h7FFF}));
      chk("add_wrap_b", 128'({obs_q[0][66], obs_q[0][49:34]}), 128'({1'b1, 16'h8000}));
      chk("abs_sat_a",  128'({obs_q[1][32], obs_q[1][15:0]}),  128'({1'b1, 16'h7FFF}));
      chk("abs_wrap_b", 128'({obs_q[1][66], obs_q[1][49:34]}), 128'({1'b1, 16'h8000}));
      chk("mlt_int_a",  128'({obs_q[2][32], obs_q[2][15:0]}),  128'({1'b1, 16'h7FFF}));
      chk("mlt_q8_b",   128'({obs_q[2][66], obs_q[2][49:34]}), 128'({1'b0, 16'h0180}));
      chk("mlt_round_b", 128'({obs_q[3][66], obs_q[3][49:34]}), 128'({1'b0, 16'h0001}));
    end

    // MAC packet of four beats, then first beat of the next packet.
    obs_q.delete();
    for (int k = 0; k < 5; k++)
      send(3'd6, 16'd2, 16'd2, 16'd2, 16'd2, (k >= 3), 1'b0);
    drain();
    chk("mac_count", 128'(obs_q.size()), 128'(5));
    if (obs_q.size() == 5) begin
      chk("mac_1", 128'(obs_q[0][31:0]), 128'({16'd4, 16'd4}));
      chk("mac_2", 128'(obs_q[1][31:0]), 128'({16'd8, 16'd8}));
      chk("mac_3", 128'(obs_q[2][31:0]), 128'({16'd12, 16'd12}));
      chk("mac_4", 128'(obs_q[3][31:0]), 128'({16'd16, 16'd16}));
      chk("mac_4_last", 128'(obs_q[3][69]), 128'(1));
      chk("mac_next", 128'(obs_q[4][31:0]), 128'({16'd4, 16'd4}));
    end

    // Random stream with random backpressure and forced stall bursts.
    rnd_mode = 1;
    low_cnt = 5;
    for (int k = 0; k < 200; k++) begin
      if (k == 100) low_cnt = 6;
      if ($urandom_range(0, 3) == 0) begin
        s_valid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      send(3'($urandom_range(0, 7)), rnd_opnd(), rnd_opnd(), rnd_opnd(), rnd_opnd(),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
    end
    rnd_mode = 0;
    drain();

    // Asynchronous reset in the middle of a MAC packet.
    send(3'd6, 16'd2, 16'd2, 16'd2, 16'd2, 1'b0, 1'b0);
    send(3'd6, 16'd2, 16'd2, 16'd2, 16'd2, 1'b0, 1'b0);
    s_valid = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      @(negedge clk);
      if (m_valid_a) got = 1'b1;
    end
    chk("mac_before_reset", 128'(got), 128'(1));
    #2 rst_n = 1'b0;
    #1 chk("reset_drops_valid", 128'({m_valid_b, m_valid_a, s_ready_a}), 128'(0));
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_mid_reset", 128'(s_ready_a), 128'(1));
    @(posedge clk); #1;
    obs_q.delete();
    send(3'd6, 16'd2, 16'd2, 16'd2, 16'd2, 1'b1, 1'b0);
    drain();
    chk("mac_after_reset_count", 128'(obs_q.size()), 128'(1));
    if (obs_q.size() == 1) chk("mac_after_reset", 128'(obs_q[0][31:0]), 128'({16'd4, 16'd4}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
